// File: rtl/timer_contagem_nivel2.sv
// Countdown timer stage: shifts keypad digits into M:SS and counts down once per 1 Hz tick.
// Optional TIMER_MIN_TENS_EN adds a minutes-tens digit (max 99:59).
module timer_contagem_nivel2 #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enable,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
`ifdef TIMER_MIN_TENS_EN
  output logic [3:0] min_tens,
`endif
  output logic       zero,
  output logic       done
);

  localparam logic [3:0] ST_MAX    = 4'(SEC_TENS_MAX);
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   load_prev;
  logic                   tick_prev;
  logic                   key_evt;
  logic                   tick_evt;

  logic [3:0] so_n;
  logic [3:0] st_n;
  logic [3:0] mo_n;
  logic       done_n;
`ifdef TIMER_MIN_TENS_EN
  logic [3:0] mt_n;
`endif

  // Synchronizers preset to the idle level so releasing clear creates no edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      load_sync <= '1;
      load_prev <= 1'b1;
      tick_sync <= '0;
      tick_prev <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], loadn};
      load_prev <= load_sync[SYNC_STAGES-1];
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], pgt_1Hz};
      tick_prev <= tick_sync[SYNC_STAGES-1];
    end
  end

  assign key_evt  = load_prev & ~load_sync[SYNC_STAGES-1];
  assign tick_evt = ~tick_prev & tick_sync[SYNC_STAGES-1];

`ifdef TIMER_MIN_TENS_EN
  assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                (min_ones == 4'd0) && (min_tens == 4'd0);
`else
  assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (min_ones == 4'd0);
`endif

  // Entry shift when disabled, BCD borrow countdown when enabled
  always_comb begin
    so_n   = sec_ones;
    st_n   = sec_tens;
    mo_n   = min_ones;
    done_n = 1'b0;
`ifdef TIMER_MIN_TENS_EN
    mt_n   = min_tens;
`endif
    if (!enable) begin
      if (key_evt && (D <= DIGIT_MAX) && (sec_ones <= ST_MAX)) begin
`ifdef TIMER_MIN_TENS_EN
        mt_n = min_ones;
`endif
        mo_n = sec_tens;
        st_n = sec_ones;
        so_n = D;
      end
    end else if (tick_evt && !zero) begin
      if (sec_ones != 4'd0) begin
        so_n = sec_ones - 4'd1;
      end else begin
        so_n = DIGIT_MAX;
        if (sec_tens != 4'd0) begin
          st_n = sec_tens - 4'd1;
        end else begin
          st_n = ST_MAX;
`ifdef TIMER_MIN_TENS_EN
          if (min_ones != 4'd0) begin
            mo_n = min_ones - 4'd1;
          end else begin
            mo_n = DIGIT_MAX;
            mt_n = min_tens - 4'd1;
          end
`else
          mo_n = min_ones - 4'd1;
`endif
        end
      end
`ifdef TIMER_MIN_TENS_EN
      done_n = (so_n == 4'd0) && (st_n == 4'd0) && (mo_n == 4'd0) && (mt_n == 4'd0);
`else
      done_n = (so_n == 4'd0) && (st_n == 4'd0) && (mo_n == 4'd0);
`endif
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      done     <= 1'b0;
`ifdef TIMER_MIN_TENS_EN
      min_tens <= 4'd0;
`endif
    end else begin
      sec_ones <= so_n;
      sec_tens <= st_n;
      min_ones <= mo_n;
      done     <= done_n;
`ifdef TIMER_MIN_TENS_EN
      min_tens <= mt_n;
`endif
    end
  end

endmodule

// File: tb/tb_timer_contagem_nivel2.sv
// Scoreboard bench for timer_contagem_nivel2; model keeps time as total seconds.
// Exercises the TIMER_MIN_TENS_EN variant when that macro is defined.
module tb_timer_contagem_nivel2;

  localparam int unsigned SYNC_STAGES  = 2;
  localparam int unsigned SEC_TENS_MAX = 5;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1Hz = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       zero, done;
`ifdef TIMER_MIN_TENS_EN
  logic [3:0] min_tens;
`endif

  always #5 clk = ~clk;

  timer_contagem_nivel2 #(.SYNC_STAGES(SYNC_STAGES), .SEC_TENS_MAX(SEC_TENS_MAX)) dut (
    .clk      (clk),
    .clear    (clear),
    .D        (D),
    .loadn    (loadn),
    .pgt_1Hz  (pgt_1Hz),
    .enable   (enable),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
`ifdef TIMER_MIN_TENS_EN
    .min_tens (min_tens),
`endif
    .zero     (zero),
    .done     (done)
  );

  typedef struct {
    string       tag;
    logic [15:0] digits;
    logic        zero;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_mt = 0, m_mo = 0, m_st = 0, m_so = 0;
  logic m_done = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_digits();
`ifdef TIMER_MIN_TENS_EN
    return {min_tens, min_ones, sec_tens, sec_ones};
`else
    return {4'd0, min_ones, sec_tens, sec_ones};
`endif
  endfunction

  function automatic int m_total();
    return (m_mt * 10 + m_mo) * 60 + m_st * 10 + m_so;
  endfunction

  task automatic m_set(input int t);
    m_mt = (t / 60) / 10;
    m_mo = (t / 60) % 10;
    m_st = (t % 60) / 10;
    m_so = (t % 60) % 10;
  endtask

  task automatic sb_push(input string tag);
    exp_t e;
    e.tag    = tag;
    e.digits = {4'(m_mt), 4'(m_mo), 4'(m_st), 4'(m_so)};
    e.zero   = (m_total() == 0);
    e.done   = m_done;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, ".dig"}, dut_digits(), e.digits);
      check_val({e.tag, ".zero"}, 16'(zero), 16'(e.zero));
      check_val({e.tag, ".done"}, 16'(done), 16'(e.done));
    end
  endtask

  // One key press and/or tick: checks latency, one-clk done, and no event on release
  task automatic stim(input string tag, input bit key, input bit tick, input logic [3:0] d);
    @(negedge clk);
    D = d;
    if (key) loadn = 1'b0;
    if (tick) pgt_1Hz = 1'b1;
    m_done = 1'b0;
    sb_push({tag, ".pre"});
    if (!enable && key && int'(d) <= 9 && m_so <= int'(SEC_TENS_MAX)) begin
`ifdef TIMER_MIN_TENS_EN
      m_mt = m_mo;
`endif
      m_mo = m_st;
      m_st = m_so;
      m_so = int'(d);
    end else if (enable && tick && m_total() > 0) begin
      m_set(m_total() - 1);
      m_done = (m_total() == 0);
    end
    sb_push({tag, ".post"});
    m_done = 1'b0;
    sb_push({tag, ".after"});
    repeat (SYNC_STAGES) @(negedge clk);
    sb_compare();
    @(negedge clk);
    sb_compare();
    @(negedge clk);
    sb_compare();
    repeat (key ? 46 : 2) @(negedge clk);
    loadn   = 1'b1;
    pgt_1Hz = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    sb_push({tag, ".rel"});
    sb_compare();
  endtask

  // Clear asserted mid-cycle and checked before the next clock edge
  task automatic do_clear(input string tag);
    @(negedge clk);
    #2 clear = 1'b1;
    #1;
    m_set(0);
    m_done = 1'b0;
    sb_push({tag, ".async"});
    sb_compare();
    @(negedge clk);
    clear = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    sb_push({tag, ".rel"});
    sb_compare();
  endtask

  initial begin
    #2 clear = 1'b1;
    #1;
    sb_push("por");
    sb_compare();
    repeat (3) @(negedge clk);
    clear = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    sb_push("por.rel");
    sb_compare();

    stim("k1", 1, 0, 4'd1);
    stim("k3", 1, 0, 4'd3);
    stim("k0", 1, 0, 4'd0);
    stim("k5", 1, 0, 4'd5);
    stim("k4", 1, 0, 4'd4);
    stim("k3b", 1, 0, 4'd3);
    do_clear("clr543");

    stim("k7", 1, 0, 4'd7);
    stim("rej2", 1, 0, 4'd2);
    stim("rejC", 1, 0, 4'hC);

    do_clear("clr007");
    stim("l1", 1, 0, 4'd1);
    stim("l0a", 1, 0, 4'd0);
    stim("l0b", 1, 0, 4'd0);
    @(negedge clk) enable = 1'b1;
    stim("t059", 0, 1, 4'd0);
    for (int i = 0; i < 58; i++) stim($sformatf("tk%0d", i), 0, 1, 4'd0);
    stim("tzero", 0, 1, 4'd0);
    stim("tstay", 0, 1, 4'd0);

    stim("en_key9", 1, 0, 4'd9);
    @(negedge clk) enable = 1'b0;
    stim("k2", 1, 0, 4'd2);
    stim("frozen", 0, 1, 4'd0);
    @(negedge clk) enable = 1'b1;
    stim("both", 1, 1, 4'd9);

    do_clear("clr_en");
    repeat (4) @(negedge clk);
    sb_push("en_at_zero");
    sb_compare();

`ifdef TIMER_MIN_TENS_EN
    @(negedge clk) enable = 1'b0;
    stim("m1", 1, 0, 4'd1);
    stim("m0a", 1, 0, 4'd0);
    stim("m0b", 1, 0, 4'd0);
    stim("m0c", 1, 0, 4'd0);
    @(negedge clk) enable = 1'b1;
    stim("m959", 0, 1, 4'd0);
    stim("m958", 0, 1, 4'd0);
    do_clear("mclr");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
